// File: rtl/apb3_master_bridge_if.sv
// Bus bundle between the CPU load/store port, the bridge and the APB3 target.
// The master modport is the bridge's view; the slave modport is the CPU and peripheral side.
interface apb3_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_req_write;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_rdata;
  logic              cpu_rsp_err;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_write,
    input  PRDATA, PREADY, PSLVERR,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_write,
    output PRDATA, PREADY, PSLVERR,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb3_master_bridge.sv
// CPU request/response to APB3 initiator: one transfer at a time, wait states honoured,
// slave errors reported, and transfers stuck beyond TIMEOUT wait cycles aborted.
module apb3_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  apb3_master_bridge_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  // Abort fires from the last wait cycle, so the counter is compared to TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            paddr_q   <= bus.cpu_req_addr;
            pwdata_q  <= bus.cpu_req_wdata;
            pwrite_q  <= bus.cpu_req_write;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // Completion takes priority over a timeout reached in the same cycle.
          if (bus.PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.PSLVERR;
            rsp_rdata_q <= (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
            state_q     <= IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_req_ready = (state_q == IDLE);
  assign bus.cpu_rsp_valid = rsp_valid_q;
  assign bus.cpu_rsp_rdata = rsp_rdata_q;
  assign bus.cpu_rsp_err   = rsp_err_q;
  assign bus.PADDR         = paddr_q;
  assign bus.PWDATA        = pwdata_q;
  assign bus.PWRITE        = pwrite_q;
  assign bus.PSEL          = psel_q;
  assign bus.PENABLE       = penable_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge with TIMEOUT=4; the APB slave and CPU are driven by the tasks.
module tb_apb3_master_bridge;

  logic PCLK;
  logic PRESETN;
  int   checks;
  int   errors;

  apb3_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb3_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .bus     (bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.cpu_req_write = 1'b0;
    bus.PRDATA        = '0;
    bus.PREADY        = 1'b0;
    bus.PSLVERR       = 1'b0;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid, bus.cpu_rsp_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid, bus.cpu_rsp_err});
    end
    checks++;
    if ({bus.PADDR, bus.PWDATA, bus.cpu_rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: paddr %h pwdata %h rdata %h required all 0",
               bus.PADDR, bus.PWDATA, bus.cpu_rsp_rdata);
    end
    #3 PRESETN = 1'b1;
    tick();
    checks++;
    if (bus.cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.cpu_req_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hFFFF_0000;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_0104;
    bus.cpu_req_wdata = 32'hDEAD_BEEF;
    bus.cpu_req_write = 1'b1;
    tick();  // N+1: SETUP
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_wdata = 32'h0;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_req_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL wr_setup: psel/pen/pwrite/ready %b required 1010",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_req_ready});
    end
    checks++;
    if (bus.PADDR !== 32'h0000_0104 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_setup_bus: paddr %h pwdata %h required 00000104 deadbeef", bus.PADDR, bus.PWDATA);
    end
    tick();  // N+2: ACCESS
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid} !== 3'b110 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_access: psel/pen/rsp %b pwdata %h required 110 deadbeef",
               {bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid}, bus.PWDATA);
    end
    tick();  // N+3: response
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE, bus.cpu_req_ready} !== 5'b10001
        || bus.cpu_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_rsp: vld/err/psel/pen/ready %b rdata %h required 10001 00000000",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE, bus.cpu_req_ready}, bus.cpu_rsp_rdata);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.PADDR !== 32'h0000_0104) begin
      errors++;
      $display("FAIL wr_after: rsp_valid %b paddr %h required 0 00000104", bus.cpu_rsp_valid, bus.PADDR);
    end
    idle_inputs();
  endtask

  task automatic test_wait_read();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4000_0010;
    bus.cpu_req_write = 1'b0;
    tick();  // N+1
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = 32'h0;
    tick();  // N+2: first ACCESS cycle
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid} !== 4'b1100 || bus.PADDR !== 32'h4000_0010) begin
        errors++;
        $display("FAIL rd_wait%0d: psel/pen/pwrite/rsp %b paddr %h required 1100 40000010",
                 i, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid}, bus.PADDR);
      end
      tick();
    end
    // N+5: fourth ACCESS cycle, which is also where TIMEOUT=4 would fire without PREADY
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL rd_wait3: psel/pen/rsp %b required 110", {bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid});
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    tick();  // N+6
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0;
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL} !== 3'b100 || bus.cpu_rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_rsp: vld/err/psel %b rdata %h required 100 12345678",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL}, bus.cpu_rsp_rdata);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_hold: rsp_valid %b rdata %h required 0 12345678", bus.cpu_rsp_valid, bus.cpu_rsp_rdata);
    end
  endtask

  task automatic test_slverr();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4000_0020;
    bus.cpu_req_write = 1'b0;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hAAAA_5555;
    tick();
    idle_inputs();
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE} !== 4'b1100 || bus.cpu_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL slverr_rsp: vld/err/psel/pen %b rdata %h required 1100 00000000",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE}, bus.cpu_rsp_rdata);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL slverr_hold: rsp_valid %b err %b required 0 1", bus.cpu_rsp_valid, bus.cpu_rsp_err);
    end
  endtask

  task automatic test_timeout();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4000_0030;
    bus.cpu_req_write = 1'b0;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();  // N+2
    tick();
    tick();
    tick();  // N+5: last ACCESS cycle before the abort
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL to_pending: psel/pen/rsp %b required 110", {bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid});
    end
    tick();  // N+6
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE, bus.cpu_req_ready} !== 5'b11001
        || bus.cpu_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_abort: vld/err/psel/pen/ready %b rdata %h required 11001 00000000",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err, bus.PSEL, bus.PENABLE, bus.cpu_req_ready}, bus.cpu_rsp_rdata);
    end
    tick();
    checks++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin
      errors++;
      $display("FAIL to_after: rsp_valid %b psel %b required 0 0", bus.cpu_rsp_valid, bus.PSEL);
    end
  endtask

  task automatic test_back_to_back();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0BAD_F00D;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_0200;
    bus.cpu_req_wdata = 32'hCAFE_0001;
    bus.cpu_req_write = 1'b1;
    tick();  // N+1: first SETUP
    checks++;
    if (bus.PSEL !== 1'b1 || bus.PWRITE !== 1'b1 || bus.PADDR !== 32'h0000_0200) begin
      errors++;
      $display("FAIL b2b_setup1: psel %b pwrite %b paddr %h required 1 1 00000200", bus.PSEL, bus.PWRITE, bus.PADDR);
    end
    bus.cpu_req_addr  = 32'h0000_0300;
    bus.cpu_req_wdata = 32'h0;
    bus.cpu_req_write = 1'b0;
    tick();
    tick();  // N+3: first response and second acceptance
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_req_ready, bus.cpu_rsp_err} !== 3'b110 || bus.cpu_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_rsp1: vld/ready/err %b rdata %h required 110 00000000",
               {bus.cpu_rsp_valid, bus.cpu_req_ready, bus.cpu_rsp_err}, bus.cpu_rsp_rdata);
    end
    tick();  // N+4: second SETUP
    bus.cpu_req_valid = 1'b0;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid} !== 4'b1000 || bus.PADDR !== 32'h0000_0300) begin
      errors++;
      $display("FAIL b2b_setup2: psel/pen/pwrite/rsp %b paddr %h required 1000 00000300",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cpu_rsp_valid}, bus.PADDR);
    end
    tick();
    tick();  // N+6: second response
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err} !== 2'b10 || bus.cpu_rsp_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL b2b_rsp2: vld/err %b rdata %h required 10 0badf00d",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err}, bus.cpu_rsp_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4000_0040;
    bus.cpu_req_write = 1'b0;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();  // ACCESS, slave stalling
    #2 PRESETN = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid, bus.cpu_req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_async: psel/pen/rsp/ready %b required 0001",
               {bus.PSEL, bus.PENABLE, bus.cpu_rsp_valid, bus.cpu_req_ready});
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_rsp_valid === 1'b1) pulses++;
    end
    #2 PRESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_rsp: pulses %0d ready %b required 0 1", pulses, bus.cpu_req_ready);
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h5A5A_A5A5;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4000_0044;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.cpu_rsp_valid, bus.cpu_rsp_err} !== 2'b10 || bus.cpu_rsp_rdata !== 32'h5A5A_A5A5) begin
      errors++;
      $display("FAIL rst_recover: vld/err %b rdata %h required 10 5a5aa5a5",
               {bus.cpu_rsp_valid, bus.cpu_rsp_err}, bus.cpu_rsp_rdata);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
